// File: rtl/whitening_pkg.sv
// Shared state / phase encoding for the whitening sequencer and the top-level FastICA controller.
package whitening_pkg;

    localparam int PHASE_W = 4;

    typedef enum logic [PHASE_W-1:0] {
        S_IDLE   = 4'd0,
        S_SUM    = 4'd1,
        S_DIV    = 4'd2,
        S_SUBCOV = 4'd3,
        S_CDRAIN = 4'd4,
        S_SHIFT  = 4'd5,
        S_QR     = 4'd6,
        S_EIG    = 4'd7,
        S_MV1    = 4'd8,
        S_MV2    = 4'd9,
        S_MULTZ  = 4'd10,
        S_ZDRAIN = 4'd11,
        S_DONE   = 4'd12
    } wstate_t;

endpackage

// File: rtl/whitening_phase_cnt.sv
// Per-state cycle counter: cleared on every state change, flags the last cycle of a state of length len.
module whitening_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] cnt,
    output logic             last_cycle
);

    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else            cnt <= cnt + CNT_W'(1);
    end

    assign last_cycle = (cnt == len - CNT_W'(1));

endmodule

// File: rtl/whitening_seq_ctrl.sv
// Whitening stage sequencer: centering, covariance, QR/eigen, V and Z multiplies.
// Optional QR watchdog with sticky error output under macro WHITEN_QR_TIMEOUT_EN.
module whitening_seq_ctrl
    import whitening_pkg::*;
#(
`ifdef WHITEN_QR_TIMEOUT_EN
    parameter int QR_TIMEOUT = 1024,
`endif
    parameter int N_SAMPLES  = 128,
    parameter int CEN_LAT    = 2,
    parameter int COV_DRAIN  = 2,
    parameter int EIG_CYCLES = 4,
    parameter int MULT_LAT   = 2,
    parameter int CNT_W      = $clog2(N_SAMPLES + CEN_LAT + 1)
) (
    input  logic         CLK_Whitening,
    input  logic         RST_Whitening,
    input  logic         GO_whitening,
    input  logic         QR_busy,
    output logic         Whitening_busy,
    output logic         Whitening_done,
    output logic         En_mem1,
    output logic         GO_cen,
    output logic         En_mem2,
    output logic         GO_cov,
    output logic         GO_QR,
    output logic         En_eig,
    output logic         En_multi_1,
    output logic         En_multi_2,
    output logic         En_mem3,
    output logic         R_w1,
`ifdef WHITEN_QR_TIMEOUT_EN
    output logic         Whitening_err,
`endif
    output logic [3:0]   phase
);

    wstate_t          state, state_nx;
    logic [CNT_W-1:0] cnt, state_len;
    logic             last_cycle, cnt_clr;
    logic             qr_seen, qr_ok, qr_tmo;

    always_ff @(posedge CLK_Whitening) begin
        if (RST_Whitening) state <= S_IDLE;
        else               state <= state_nx;
    end

    // QR_busy seen during the entry cycle counts, so the flag is only cleared outside QR.
    always_ff @(posedge CLK_Whitening) begin
        if (RST_Whitening || state != S_QR) qr_seen <= 1'b0;
        else if (QR_busy)                   qr_seen <= 1'b1;
    end

    assign qr_ok = (state == S_QR) && qr_seen && !QR_busy;

`ifdef WHITEN_QR_TIMEOUT_EN
    localparam int TMO_W = $clog2(QR_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge CLK_Whitening) begin
        if (RST_Whitening || state != S_QR) tmo_cnt <= '0;
        else                                tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    assign qr_tmo = (tmo_cnt == TMO_W'(QR_TIMEOUT - 1));

    always_ff @(posedge CLK_Whitening) begin
        if (RST_Whitening)                            Whitening_err <= 1'b0;
        else if (state == S_IDLE && GO_whitening)     Whitening_err <= 1'b0;
        else if (state == S_QR && qr_tmo && !qr_ok)   Whitening_err <= 1'b1;
    end
`else
    assign qr_tmo = 1'b0;
`endif

    always_comb begin
        case (state)
            S_SUM:    state_len = CNT_W'(N_SAMPLES);
            S_SUBCOV: state_len = CNT_W'(N_SAMPLES + CEN_LAT);
            S_CDRAIN: state_len = CNT_W'(COV_DRAIN);
            S_EIG:    state_len = CNT_W'(EIG_CYCLES);
            S_MULTZ:  state_len = CNT_W'(N_SAMPLES);
            S_ZDRAIN: state_len = CNT_W'(MULT_LAT);
            default:  state_len = CNT_W'(1);
        endcase
    end

    whitening_phase_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (CLK_Whitening),
        .rst        (RST_Whitening),
        .clr        (cnt_clr),
        .len        (state_len),
        .cnt        (cnt),
        .last_cycle (last_cycle)
    );

    always_comb begin
        state_nx       = state;
        Whitening_done = 1'b0;
        En_mem1        = 1'b0;
        GO_cen         = 1'b0;
        En_mem2        = 1'b0;
        GO_cov         = 1'b0;
        GO_QR          = 1'b0;
        En_eig         = 1'b0;
        En_multi_1     = 1'b0;
        En_multi_2     = 1'b0;
        En_mem3        = 1'b0;
        R_w1           = 1'b0;
        case (state)
            S_IDLE: if (GO_whitening) state_nx = S_SUM;
            S_SUM: begin
                En_mem1 = 1'b1;
                GO_cen  = 1'b1;
                if (last_cycle) state_nx = S_DIV;
            end
            S_DIV: begin
                GO_cen   = 1'b1;
                state_nx = S_SUBCOV;
            end
            S_SUBCOV: begin
                // cov starts CEN_LAT cycles behind the centering read and drains it after mem1 stops
                GO_cen  = 1'b1;
                En_mem1 = (cnt < CNT_W'(N_SAMPLES));
                En_mem2 = (cnt >= CNT_W'(CEN_LAT));
                GO_cov  = (cnt >= CNT_W'(CEN_LAT));
                R_w1    = (cnt >= CNT_W'(CEN_LAT));
                if (last_cycle) state_nx = S_CDRAIN;
            end
            S_CDRAIN: begin
                GO_cov = 1'b1;
                if (last_cycle) state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                GO_cov   = 1'b1;
                state_nx = S_QR;
            end
            S_QR: begin
                GO_QR = 1'b1;
                if (qr_ok)       state_nx = S_EIG;
                else if (qr_tmo) state_nx = S_IDLE;
            end
            S_EIG: begin
                En_eig = 1'b1;
                if (last_cycle) state_nx = S_MV1;
            end
            S_MV1: begin
                En_mem2    = 1'b1;
                En_multi_1 = 1'b1;
                state_nx   = S_MV2;
            end
            S_MV2: begin
                En_mem2    = 1'b1;
                En_multi_1 = 1'b1;
                En_multi_2 = 1'b1;
                state_nx   = S_MULTZ;
            end
            S_MULTZ: begin
                En_mem2    = 1'b1;
                En_multi_2 = 1'b1;
                En_mem3    = (cnt >= CNT_W'(MULT_LAT));
                if (last_cycle) state_nx = S_ZDRAIN;
            end
            S_ZDRAIN: begin
                En_multi_2 = 1'b1;
                En_mem3    = 1'b1;
                if (last_cycle) state_nx = S_DONE;
            end
            S_DONE: begin
                Whitening_done = 1'b1;
                state_nx       = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign cnt_clr        = (state_nx != state);
    assign Whitening_busy = (state != S_IDLE);
    assign phase          = state;

endmodule
